// File: rtl/guard_sprite_sequencer.sv
// guard_sprite_sequencer
// Controller for the guard sprite datapath. Once per video frame it latches
// the guard's position and facing and advances the walk-animation FSM
// (stand / walk A / walk B, each walk pose held HOLD_FRAMES frames). Every
// pixel clock it computes the shared sprite-ROM texel address and registers
// the pose, mirror and hit flags so they line up with the 1-cycle ROM output.
//
// Ports:
//   vga_clk      in   pixel clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   DrawX/DrawY  in   current pixel column / row (10 bits)
//   blank        in   1 = active display region
//   guard_x/y    in   requested sprite top-left (latched on frame tick)
//   moving       in   guard is walking (sampled on frame tick)
//   facing_right in   1 = mirror the sprite (latched on frame tick)
//   rom_address  out  col + row*SPR_W, combinational, 0 outside the sprite
//   frame_sel    out  pose: 0 stand, 1 walk A, 2 walk B (registered)
//   mirror       out  latched facing (registered)
//   in_sprite    out  pixel inside sprite box and blank=1 (registered)
module guard_sprite_sequencer #(
  parameter int SPR_W       = 21,
  parameter int SPR_H       = 45,
  parameter int SCALE_SHIFT = 1,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic [9:0]  guard_x,
  input  logic [9:0]  guard_y,
  input  logic        moving,
  input  logic        facing_right,
  output logic [10:0] rom_address,
  output logic [1:0]  frame_sel,
  output logic        mirror,
  output logic        in_sprite
);

  typedef enum logic [1:0] {
    STAND  = 2'd0,
    WALK_A = 2'd1,
    WALK_B = 2'd2
  } pose_t;

  localparam logic [10:0] BOX_W     = 11'(SPR_W << SCALE_SHIFT);
  localparam logic [10:0] BOX_H     = 11'(SPR_H << SCALE_SHIFT);
  localparam logic [10:0] COL_LAST  = 11'(SPR_W - 1);
  localparam logic [10:0] ROW_PITCH = 11'(SPR_W);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

  pose_t       state_r, state_next_s;
  logic [7:0]  cnt_r, cnt_next_s;
  logic [9:0]  pos_x_r, pos_y_r;
  logic        face_r;
  logic        top_q_r;
  logic        top_s, tick_s;
  logic [10:0] dx_s, dy_s, x_end_s, y_end_s;
  logic [10:0] col_raw_s, col_s, row_s, addr_s;
  logic        hit_s;

  // The tick is the rising edge of the (0,0) condition, so holding the
  // beam at the origin for several cycles still yields a single pulse.
  assign top_s  = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign tick_s = top_s && !top_q_r;

  // Hit test in 11 bits so a sprite near the right/bottom edge clips
  // instead of wrapping around to the left/top.
  assign dx_s    = {1'b0, DrawX} - {1'b0, pos_x_r};
  assign dy_s    = {1'b0, DrawY} - {1'b0, pos_y_r};
  assign x_end_s = {1'b0, pos_x_r} + BOX_W;
  assign y_end_s = {1'b0, pos_y_r} + BOX_H;
  assign hit_s   = ({1'b0, DrawX} >= {1'b0, pos_x_r}) && ({1'b0, DrawX} < x_end_s) &&
                   ({1'b0, DrawY} >= {1'b0, pos_y_r}) && ({1'b0, DrawY} < y_end_s);

  assign col_raw_s   = dx_s >> SCALE_SHIFT;
  assign row_s       = dy_s >> SCALE_SHIFT;
  assign col_s       = face_r ? (COL_LAST - col_raw_s) : col_raw_s;
  assign addr_s      = col_s + row_s * ROW_PITCH;
  assign rom_address = hit_s ? addr_s : 11'd0;

  // Walk FSM next state; it only moves on a frame tick.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (tick_s) begin
      case (state_r)
        STAND: begin
          if (moving) begin
            state_next_s = WALK_A;
            cnt_next_s   = 8'd0;
          end else begin
            state_next_s = STAND;
          end
        end
        WALK_A, WALK_B: begin
          if (!moving) begin
            state_next_s = STAND;
            cnt_next_s   = 8'd0;
          end else if (cnt_r == HOLD_LAST) begin
            state_next_s = (state_r == WALK_A) ? WALK_B : WALK_A;
            cnt_next_s   = 8'd0;
          end else begin
            cnt_next_s = cnt_r + 8'd1;
          end
        end
        default: begin
          state_next_s = STAND;
          cnt_next_s   = 8'd0;
        end
      endcase
    end else begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
    end
  end

  // Frame-rate state: edge detector, FSM and per-frame latch of position/facing.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      top_q_r <= 1'b0;
      state_r <= STAND;
      cnt_r   <= 8'd0;
      pos_x_r <= 10'd0;
      pos_y_r <= 10'd0;
      face_r  <= 1'b0;
    end else begin
      top_q_r <= top_s;
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (tick_s) begin
        pos_x_r <= guard_x;
        pos_y_r <= guard_y;
        face_r  <= facing_right;
      end
    end
  end

  // Output stage, one cycle behind rom_address to match the ROM latency.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_sprite <= 1'b0;
      frame_sel <= 2'd0;
      mirror    <= 1'b0;
    end else begin
      in_sprite <= hit_s && blank;
      frame_sel <= state_r;
      mirror    <= face_r;
    end
  end

endmodule

// File: tb/tb_guard_sprite_sequencer.sv
// Testbench for guard_sprite_sequencer: table-driven pixel vectors plus
// hand-written sequences for frame ticks, walk timing and mid-frame reset.
module tb_guard_sprite_sequencer;

  logic        vga_clk;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [9:0]  guard_x, guard_y;
  logic        moving, facing_right;
  logic [10:0] rom_address;
  logic [1:0]  frame_sel;
  logic        mirror, in_sprite;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        b;
    logic [10:0] addr;
    logic        ins;
  } vec_t;

  vec_t left_v[10];
  vec_t right_v[3];
  vec_t edge_v[5];

  guard_sprite_sequencer dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .guard_x(guard_x), .guard_y(guard_y), .moving(moving),
    .facing_right(facing_right), .rom_address(rom_address),
    .frame_sel(frame_sel), .mirror(mirror), .in_sprite(in_sprite)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  // One frame tick: beam at the origin for `hold` cycles, then moves away.
  task automatic frame_tick(input int hold);
    DrawX = 10'd0;
    DrawY = 10'd0;
    for (int i = 0; i < hold; i++) cyc();
    DrawX = 10'd1;
    cyc();
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    DrawX = v.x;
    DrawY = v.y;
    blank = v.b;
    #1;
    chk({name, " addr"}, int'(rom_address), int'(v.addr));
    cyc();
    chk({name, " in_sprite"}, int'(in_sprite), int'(v.ins));
  endtask

  initial begin
    // pos (100,50), scale 2: box covers x 100..141, y 50..139
    left_v[0] = '{10'd100, 10'd50,  1'b1, 11'd0,   1'b1};
    left_v[1] = '{10'd141, 10'd139, 1'b1, 11'd944, 1'b1};
    left_v[2] = '{10'd142, 10'd139, 1'b1, 11'd0,   1'b0};
    left_v[3] = '{10'd99,  10'd50,  1'b1, 11'd0,   1'b0};
    left_v[4] = '{10'd100, 10'd140, 1'b1, 11'd0,   1'b0};
    left_v[5] = '{10'd110, 10'd60,  1'b0, 11'd110, 1'b0};
    left_v[6] = '{10'd103, 10'd51,  1'b1, 11'd1,   1'b1};
    left_v[7] = '{10'd100, 10'd52,  1'b1, 11'd21,  1'b1};
    left_v[8] = '{10'd141, 10'd50,  1'b1, 11'd20,  1'b1};
    left_v[9] = '{10'd100, 10'd139, 1'b1, 11'd924, 1'b1};
    // same position, mirrored
    right_v[0] = '{10'd100, 10'd50, 1'b1, 11'd20, 1'b1};
    right_v[1] = '{10'd141, 10'd50, 1'b1, 11'd0,  1'b1};
    right_v[2] = '{10'd103, 10'd52, 1'b1, 11'd40, 1'b1};
    // pos (620,460): clipped at the screen edge, no wrap
    edge_v[0] = '{10'd620, 10'd460, 1'b1, 11'd0,   1'b1};
    edge_v[1] = '{10'd639, 10'd479, 1'b1, 11'd198, 1'b1};
    edge_v[2] = '{10'd10,  10'd470, 1'b1, 11'd0,   1'b0};
    edge_v[3] = '{10'd630, 10'd10,  1'b1, 11'd0,   1'b0};
    edge_v[4] = '{10'd5,   10'd5,   1'b1, 11'd0,   1'b0};

    reset_n = 1'b0;
    DrawX = 10'd300; DrawY = 10'd300; blank = 1'b0;
    guard_x = 10'd100; guard_y = 10'd50;
    moving = 1'b0; facing_right = 1'b0;
    repeat (3) cyc();
    chk("reset in_sprite", int'(in_sprite), 0);
    chk("reset frame_sel", int'(frame_sel), 0);
    chk("reset mirror", int'(mirror), 0);
    chk("reset addr", int'(rom_address), 0);
    reset_n = 1'b1;
    blank = 1'b1;
    cyc();
    chk("pre-tick in_sprite", int'(in_sprite), 0);

    for (int f = 0; f < 3; f++) begin
      frame_tick(1);
      chk($sformatf("stand frame %0d", f), int'(frame_sel), 0);
    end

    for (int i = 0; i < 10; i++) apply_vec($sformatf("left v%0d", i), left_v[i]);

    facing_right = 1'b1;
    frame_tick(1);
    for (int i = 0; i < 3; i++) apply_vec($sformatf("right v%0d", i), right_v[i]);
    chk("mirror set", int'(mirror), 1);

    facing_right = 1'b0;
    moving = 1'b1;
    for (int f = 0; f < 24; f++) begin
      // frame 3 holds the origin for 4 cycles; it must count as one tick
      frame_tick((f == 3) ? 4 : 1);
      chk($sformatf("walk frame %0d", f), int'(frame_sel), ((f / 8) % 2 == 0) ? 1 : 2);
    end

    // mid-frame asynchronous reset while walking and inside the sprite
    DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
    cyc();
    chk("pre-reset in_sprite", int'(in_sprite), 1);
    chk("pre-reset frame_sel", int'(frame_sel), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset in_sprite", int'(in_sprite), 0);
    chk("async reset frame_sel", int'(frame_sel), 0);
    #2 reset_n = 1'b1;
    cyc();
    chk("post-reset frame_sel", int'(frame_sel), 0);

    frame_tick(1);
    chk("walk after reset", int'(frame_sel), 1);
    moving = 1'b0;
    frame_tick(1);
    chk("drop moving", int'(frame_sel), 0);

    guard_x = 10'd620; guard_y = 10'd460;
    frame_tick(1);
    for (int i = 0; i < 5; i++) apply_vec($sformatf("edge v%0d", i), edge_v[i]);

    // guard_x change mid-frame must not take effect before the next tick
    guard_x = 10'd200;
    apply_vec("midframe hold", '{10'd625, 10'd465, 1'b1, 11'd44, 1'b1});
    frame_tick(1);
    apply_vec("after tick old pos", '{10'd625, 10'd465, 1'b1, 11'd0, 1'b0});
    apply_vec("after tick new pos", '{10'd205, 10'd465, 1'b1, 11'd44, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
